// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the sequential FP units
// (floating_mul_32b_seq, floating_div_32b).
// Contents: field widths, bias, canonical QNaN/Inf encodings, FSM state
// codes, the operand class type and a classifier helper.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_MULT   = 3'd2;
  localparam logic [2:0] ST_NORM   = 3'd3;
  localparam logic [2:0] ST_ROUND  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  // Subnormals (exponent 0, non-zero fraction) are classed as zero.
  function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
    fp_class_t cls;
    if (e == {EXP_W{1'b0}}) begin
      cls = FP_ZERO;
    end else if (e == {EXP_W{1'b1}}) begin
      cls = (m == {MAN_W{1'b0}}) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/floating_mul_32b_seq_shiftadd.sv
// fp_mant_shiftadd: 24x24 iterative unsigned multiplier, one partial product
// per clock (multiplicand LSB first).
// Ports: clk, rst (async active-high), start (loads ma/mb, clears accumulator),
//        ma/mb (mantissas with hidden bit), busy (iterating),
//        done (high in the cycle whose edge adds the final partial product),
//        prod (48-bit accumulator; final once busy has dropped).
module fp_mant_shiftadd
  import fp32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MAN_W:0]       ma,
  input  logic [MAN_W:0]       mb,
  output logic                 busy,
  output logic                 done,
  output logic [2*MAN_W+1:0]   prod
);

  localparam int PW = 2 * (MAN_W + 1);

  logic [MAN_W:0]  mcand_r;
  logic [PW-1:0]   mplier_r;
  logic [PW-1:0]   acc_r;
  logic [4:0]      cnt_r;
  logic            busy_r;

  // Load on start, then shift-add one multiplicand bit per clock for counts 0..MAN_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= ma;
      mplier_r <= {{(MAN_W+1){1'b0}}, mb};
      acc_r    <= '0;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= acc_r + (mcand_r[0] ? mplier_r : {PW{1'b0}});
      mcand_r  <= mcand_r >> 1;
      mplier_r <= mplier_r << 1;
      cnt_r    <= cnt_r + 5'd1;
      busy_r   <= (cnt_r != 5'(MAN_W));
    end
  end

  assign busy = busy_r;
  // Combinational so the owner can leave its MULT state on the same edge
  // that adds the last partial product.
  assign done = busy_r & (cnt_r == 5'(MAN_W));
  assign prod = acc_r;

endmodule

// File: rtl/floating_mul_32b_seq.sv
// floating_mul_32b_seq: multi-cycle IEEE-754 single-precision multiplier.
// Ports: clk, rst (async active-high), a/b operands (sampled when accepted),
//        start (sampled in IDLE/DONE only), c product (held until the next
//        complete), complete (one-cycle pulse), ov (exponent overflow for c).
// An op occupies UNPACK, 24 MULT cycles, NORM, ROUND and DONE: 28 cycles,
// and start held high in DONE chains the next op with no gap.
// Build option: define FMUL_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the result is truncated toward zero.
module floating_mul_32b_seq
  import fp32_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          start,
  output logic [W-1:0]  c,
  output logic          complete,
  output logic          ov
);

  localparam int ES_W = EXP_W + 2;       // signed exponent working width
  localparam int PW   = 2 * (MAN_W + 1);

  logic [2:0]       state_r;
  logic [W-1:0]     a_r, b_r;
  logic             sign_r, spec_r;
  logic [W-1:0]     spec_val_r;
  logic [ES_W-1:0]  exp_r;
  logic [MAN_W-1:0] man_r;
`ifdef FMUL_ROUND_NEAREST_EN
  logic             guard_r, sticky_r;
`endif

  logic             mul_busy_s, mul_done_s;
  logic [PW-1:0]    prod_s;

  fp_mant_shiftadd u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (state_r == ST_UNPACK),
    .ma    ({1'b1, a_r[MAN_W-1:0]}),
    .mb    ({1'b1, b_r[MAN_W-1:0]}),
    .busy  (mul_busy_s),
    .done  (mul_done_s),
    .prod  (prod_s)
  );

`ifndef FMUL_ROUND_NEAREST_EN
  // Bits below the kept mantissa only feed guard/sticky, which truncation drops.
  logic unused_low_s;
  assign unused_low_s = ^prod_s[PW-3-MAN_W:0];
`endif

  fp_class_t        cls_a_s, cls_b_s;
  logic             sign_s, spec_s;
  logic [W-1:0]     spec_val_s;
  logic [ES_W-1:0]  exp_sum_s;

  // Unpack: classify operands, pick the special-case result, form ea+eb-bias.
  always_comb begin
    cls_a_s   = fp_classify(a_r[W-2:MAN_W], a_r[MAN_W-1:0]);
    cls_b_s   = fp_classify(b_r[W-2:MAN_W], b_r[MAN_W-1:0]);
    sign_s    = a_r[W-1] ^ b_r[W-1];
    exp_sum_s = ES_W'(a_r[W-2:MAN_W]) + ES_W'(b_r[W-2:MAN_W]) - ES_W'(BIAS);
    if ((cls_a_s == FP_NAN) || (cls_b_s == FP_NAN) ||
        ((cls_a_s == FP_ZERO) && (cls_b_s == FP_INF)) ||
        ((cls_a_s == FP_INF) && (cls_b_s == FP_ZERO))) begin
      spec_s     = 1'b1;
      spec_val_s = QNAN;
    end else if ((cls_a_s == FP_INF) || (cls_b_s == FP_INF)) begin
      spec_s     = 1'b1;
      spec_val_s = INF | {sign_s, {(W-1){1'b0}}};
    end else if ((cls_a_s == FP_ZERO) || (cls_b_s == FP_ZERO)) begin
      spec_s     = 1'b1;
      spec_val_s = {sign_s, {(W-1){1'b0}}};
    end else begin
      spec_s     = 1'b0;
      spec_val_s = {W{1'b0}};
    end
  end

  logic             inc_s, ovf_s;
  logic [MAN_W:0]   man_inc_s;
  logic [ES_W-1:0]  exp_rnd_s;
  logic [W-1:0]     res_s;

  // Round, renormalise on mantissa carry-out, then saturate or flush the exponent.
  always_comb begin
`ifdef FMUL_ROUND_NEAREST_EN
    inc_s = guard_r & (sticky_r | man_r[0]);
`else
    inc_s = 1'b0;
`endif
    man_inc_s = {1'b0, man_r} + {{MAN_W{1'b0}}, inc_s};
    // On carry-out the fraction bits are already all zero, only the exponent moves.
    exp_rnd_s = exp_r + ES_W'(man_inc_s[MAN_W]);
    ovf_s     = 1'b0;
    if (spec_r) begin
      res_s = spec_val_r;
    end else if (!exp_rnd_s[ES_W-1] &&
                 (exp_rnd_s[ES_W-2:0] >= {1'b0, {EXP_W{1'b1}}})) begin
      res_s = INF | {sign_r, {(W-1){1'b0}}};
      ovf_s = 1'b1;
    end else if (exp_rnd_s[ES_W-1] || (exp_rnd_s == {ES_W{1'b0}})) begin
      res_s = {sign_r, {(W-1){1'b0}}};
    end else begin
      res_s = {sign_r, exp_rnd_s[EXP_W-1:0], man_inc_s[MAN_W-1:0]};
    end
  end

  // Control FSM and the operand/exponent/mantissa pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sign_r     <= 1'b0;
      spec_r     <= 1'b0;
      spec_val_r <= '0;
      exp_r      <= '0;
      man_r      <= '0;
`ifdef FMUL_ROUND_NEAREST_EN
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            state_r <= ST_UNPACK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_UNPACK: begin
          sign_r     <= sign_s;
          spec_r     <= spec_s;
          spec_val_r <= spec_val_s;
          exp_r      <= exp_sum_s;
          state_r    <= ST_MULT;
        end
        ST_MULT: begin
          if (mul_done_s) begin
            state_r <= ST_NORM;
          end else if (!mul_busy_s) begin
            state_r <= ST_IDLE;   // engine lost its op: recover instead of hanging
          end
        end
        ST_NORM: begin
          // Product of two 1.x values lies in [1,4): bit PW-1 set means [2,4).
          if (prod_s[PW-1]) begin
            man_r    <= prod_s[PW-2 -: MAN_W];
            exp_r    <= exp_r + ES_W'(1);
`ifdef FMUL_ROUND_NEAREST_EN
            guard_r  <= prod_s[PW-2-MAN_W];
            sticky_r <= |prod_s[PW-3-MAN_W:0];
`endif
          end else begin
            man_r    <= prod_s[PW-3 -: MAN_W];
`ifdef FMUL_ROUND_NEAREST_EN
            guard_r  <= prod_s[PW-3-MAN_W];
            sticky_r <= |prod_s[PW-4-MAN_W:0];
`endif
          end
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs: c/ov load as DONE is entered, complete pulses for DONE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c        <= '0;
      complete <= 1'b0;
      ov       <= 1'b0;
    end else begin
      complete <= (state_r == ST_ROUND);
      if (state_r == ST_ROUND) begin
        c  <= res_s;
        ov <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_floating_mul_32b_seq.sv
// Self-checking bench for floating_mul_32b_seq: directed vectors, random ops
// with operand noise while busy, a back-to-back burst and a mid-op reset.
// Expected results come from a real-arithmetic reference model below.
module tb_floating_mul_32b_seq;

  localparam int LAT = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, c;
  logic        complete, ov;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  floating_mul_32b_seq dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .start    (start),
    .c        (c),
    .complete (complete),
    .ov       (ov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then rounding of the
  // discarded remainder; returns {ov, c}.
  function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [31:0] sz;
    int          ex, ey, e, sh;
    longint      fx, fy, p, q;
`ifdef FMUL_ROUND_NEAREST_EN
    longint      rem, half;
`endif
    s  = x[31] ^ y[31];
    sz = {s, 31'd0};
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) ||
        (ex == 0 && ey == 255) || (ey == 0 && ex == 255))
      return {1'b0, 32'h7FC0_0000};
    if (ex == 255 || ey == 255)
      return {1'b0, sz | 32'h7F80_0000};
    if (ex == 0 || ey == 0)
      return {1'b0, sz};
    p  = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e++;
    end
    q = p >> sh;
`ifdef FMUL_ROUND_NEAREST_EN
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0] == 1'b1)) q++;
`endif
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {1'b1, sz | 32'h7F80_0000};
    if (e <= 0)   return {1'b0, sz};
    return {1'b0, s, 8'(e), 23'(q)};
  endfunction

  // Mostly well-scaled exponents, occasionally anything (specials, over/underflow).
  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 7) != 0) v[30:23] = 8'($urandom_range(90, 164));
    return v;
  endfunction

  // One op from IDLE; complete is expected in the LAT-th cycle counting the
  // cycle after the accepting edge as the first. With noisy set, start/a/b
  // are scrambled while the op is in flight.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [32:0] expv, input string tag, input bit noisy);
    int n;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (complete !== 1'b1 && n < 2 * LAT) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, ".lat"}, n, LAT - 1);
    chk({tag, ".c"}, c, expv[31:0]);
    chk({tag, ".ov"}, {31'd0, ov}, {31'd0, expv[32]});
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'd0, complete}, 32'd0);
    chk({tag, ".hold"}, c, expv[31:0]);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [32:0] expv;
    logic [32:0] exp_q[$];
    int          n;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.c", c, 32'd0);
    chk("reset.complete", {31'd0, complete}, 32'd0);
    chk("reset.ov", {31'd0, ov}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle.complete", {31'd0, complete}, 32'd0);

    run_op(32'h3FC0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000}, "t1", 1'b0);
    run_op(32'hBF80_0000, 32'h3F80_0000, {1'b0, 32'hBF80_0000}, "t2b", 1'b0);
    run_op(32'h0000_0000, 32'h7F80_0000, {1'b0, 32'h7FC0_0000}, "t3a", 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, {1'b0, 32'h0000_0000}, "t3b", 1'b0);
`ifdef FMUL_ROUND_NEAREST_EN
    run_op(32'h3F80_0001, 32'h3FC0_0000, {1'b0, 32'h3FC0_0002}, "t4", 1'b0);
`else
    run_op(32'h3F80_0001, 32'h3FC0_0000, {1'b0, 32'h3FC0_0001}, "t4", 1'b0);
`endif
    run_op(32'hFF80_0000, 32'h4000_0000, {1'b0, 32'hFF80_0000}, "inf", 1'b0);
    run_op(32'h8000_0000, 32'h3F80_0000, {1'b0, 32'h8000_0000}, "negzero", 1'b0);
    run_op(32'h7FC0_1234, 32'h3F80_0000, {1'b0, 32'h7FC0_0000}, "nan", 1'b0);
    run_op(32'h7F00_0000, 32'h7F00_0000, {1'b1, 32'h7F80_0000}, "t2a", 1'b0);

    // Reset in the middle of MULT: outputs clear at once, the op is discarded.
    a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.c", c, 32'd0);
    chk("midrst.complete", {31'd0, complete}, 32'd0);
    chk("midrst.ov", {31'd0, ov}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("midrst.dropped", {31'd0, complete}, 32'd0);
    run_op(32'h3FC0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000}, "postrst", 1'b0);

    // Random ops with start/a/b churn while busy.
    for (int i = 0; i < 20; i++) begin
      x = rand_op();
      y = rand_op();
      expv = ref_mul(x, y);
      run_op(x, y, expv, "rand", 1'b1);
    end

    // Back-to-back: start held high for 10 ops, completes must be LAT apart.
    x = rand_op(); y = rand_op();
    a = x; b = y; start = 1'b1;
    exp_q.push_back(ref_mul(x, y));
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      if (i > 0) begin
        @(posedge clk); #1;   // accepting edge of op i
        n = 1;
      end
      if (i < 9) begin
        x = rand_op(); y = rand_op();
        a = x; b = y;
        exp_q.push_back(ref_mul(x, y));
      end else begin
        start = 1'b0;
      end
      while (1) begin
        @(posedge clk); #1;
        n++;
        if (complete === 1'b1 || n >= 2 * LAT) break;
      end
      chk("b2b.lat", n, (i == 0) ? LAT - 1 : LAT);
      expv = exp_q.pop_front();
      chk("b2b.c", c, expv[31:0]);
      chk("b2b.ov", {31'd0, ov}, {31'd0, expv[32]});
    end
    @(posedge clk); #1;
    chk("b2b.end", {31'd0, complete}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
